xrst_settlement_ledger: RTL and testbench



---
 rtl/xrst_settlement_ledger_pkg.sv | 39 +++
 rtl/xrst_settlement_ledger_if.sv | 32 +++
 rtl/xrst_sync_fifo.sv | 63 ++++++
 rtl/xrst_settlement_ledger.sv | 166 ++++++++++++++++
 tb/tb_xrst_settlement_ledger.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xrst_settlement_ledger_pkg.sv
// Shared types and constants for the settlement ledger: record layout, tier codes, hash seed.
// The chain hash is built only when XRST_HASH_CHAIN_EN is defined.
package xrst_settlement_pkg;

  localparam int DATA_W  = 32;
  localparam int PROOF_W = 256;

  typedef struct packed {
    logic [DATA_W-1:0]  sla_id;
    logic [DATA_W-1:0]  timestamp;
    logic [DATA_W-1:0]  score;
    logic [DATA_W-1:0]  settle_a;
    logic [DATA_W-1:0]  settle_b;
    logic [DATA_W-1:0]  settle_c;
    logic [DATA_W-1:0]  stake;
    logic [7:0]         status;
    logic [PROOF_W-1:0] proof;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  localparam logic [7:0] RISK_HI    = 8'd10;
  localparam logic [7:0] LEVEL_HI   = 8'd100;
  localparam logic [7:0] RISK_MID   = 8'd30;
  localparam logic [7:0] LEVEL_MID  = 8'd90;
  localparam logic [7:0] RISK_LO    = 8'd60;
  localparam logic [7:0] LEVEL_LO   = 8'd75;
  localparam logic [7:0] RISK_NONE  = 8'd90;
  localparam logic [7:0] LEVEL_NONE = 8'd50;
  localparam logic [7:0] RISK_RST   = 8'd100;
  localparam logic [7:0] LEVEL_RST  = 8'd100;

  localparam logic [63:0] HASH_SEED = 64'h5852_5354_0000_0001;

  function automatic logic [63:0] rotl5(input logic [63:0] h);
    return {h[58:0], h[63:59]};
  endfunction

endpackage

// File: rtl/xrst_settlement_ledger_if.sv
// Record ingress and audit egress streams of the settlement ledger.
// slave = ledger side, master = settlement engine / audit export side.
interface xrst_settlement_ledger_if #(
  parameter int CH_W = 2
);
  import xrst_settlement_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [CH_W-1:0] in_ch;
  rec_t            in_rec;

  logic            out_valid;
  logic            out_ready;
  rec_t            out_rec;
  logic [CH_W-1:0] out_ch;
  logic [31:0]     out_seq;
  logic [7:0]      out_risk;
  logic [7:0]      out_level;
  logic [63:0]     out_hash;

  modport slave (
    input  in_valid, in_ch, in_rec, out_ready,
    output in_ready, out_valid, out_rec, out_ch, out_seq, out_risk, out_level, out_hash
  );

  modport master (
    output in_valid, in_ch, in_rec, out_ready,
    input  in_ready, out_valid, out_rec, out_ch, out_seq, out_risk, out_level, out_hash
  );

endinterface

// File: rtl/xrst_sync_fifo.sv
// Synchronous FIFO with a registered head word; an empty FIFO forwards a push straight
// into the head so data is visible the cycle after the write edge.
module xrst_sync_fifo #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              AW      = $clog2(DEPTH),
  localparam int              LVL_W   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic [LVL_W-1:0] level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [LVL_W-1:0] mcnt_q;
  logic [WIDTH-1:0] head_q;
  logic             hvld_q;

  logic load_d, from_mem_d, bypass_d, mem_wr_d;

  always_comb begin
    load_d     = !hvld_q || pop_i;
    from_mem_d = load_d && (mcnt_q != '0);
    bypass_d   = load_d && (mcnt_q == '0) && push_i;
    mem_wr_d   = push_i && !bypass_d;
  end

  always_ff @(posedge clk) begin
    if (mem_wr_d) mem_q[wr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      mcnt_q <= '0;
      hvld_q <= 1'b0;
      head_q <= RST_VAL;
    end else begin
      if (mem_wr_d) wr_q <= wr_q + AW'(1);
      if (from_mem_d) begin
        head_q <= mem_q[rd_q];
        rd_q   <= rd_q + AW'(1);
      end else if (bypass_d) begin
        head_q <= din_i;
      end
      if (load_d) hvld_q <= from_mem_d || bypass_d;
      mcnt_q <= mcnt_q + LVL_W'(mem_wr_d) - LVL_W'(from_mem_d);
    end
  end

  assign dout_o  = head_q;
  assign valid_o = hvld_q;
  assign level_o = mcnt_q + LVL_W'(hvld_q);

endmodule

// File: rtl/xrst_settlement_ledger.sv
// Multi-channel settlement ledger: classify, sequence and queue records for audit export.
// Define XRST_HASH_CHAIN_EN to build the accept-order chain hash; otherwise out_hash is 0.
module xrst_settlement_ledger
  import xrst_settlement_pkg::*;
#(
  parameter int  N_CH      = 4,
  parameter int  DEPTH     = 8,
  parameter int  SCORE_MAX = 1000,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int LVL_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  xrst_settlement_ledger_if.slave bus,
  input  logic [DATA_W-1:0]    thr_hi,
  input  logic [DATA_W-1:0]    thr_mid,
  input  logic [DATA_W-1:0]    thr_lo,
  input  logic [N_CH-1:0]      ch_clear,
  output logic [N_CH*16-1:0]   ch_count,
  output logic [N_CH-1:0]      ch_final,
  output logic [15:0]          reject_count,
  output logic [LVL_W-1:0]     fifo_level
);

  localparam int BASE_W = REC_W + CH_W + 32 + 8 + 8;
`ifdef XRST_HASH_CHAIN_EN
  localparam int FW = BASE_W + 64;
  localparam logic [FW-1:0] FIFO_RST = {{(REC_W + CH_W + 32){1'b0}}, RISK_RST, LEVEL_RST, 64'd0};
`else
  localparam int FW = BASE_W;
  localparam logic [FW-1:0] FIFO_RST = {{(REC_W + CH_W + 32){1'b0}}, RISK_RST, LEVEL_RST};
`endif

  function automatic logic [15:0] tier(input logic [DATA_W-1:0] s, hi, mid, lo);
    if (s >= hi)  return {RISK_HI, LEVEL_HI};
    if (s >= mid) return {RISK_MID, LEVEL_MID};
    if (s >= lo)  return {RISK_LO, LEVEL_LO};
    return {RISK_NONE, LEVEL_NONE};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic            accept_d, reject_d;
  logic [15:0]     tier_d;
  logic [31:0]     seq_q;

  logic            s1_vld_q, s1_rej_q;
  rec_t            s1_rec_q;
  logic [CH_W-1:0] s1_ch_q;
  logic [31:0]     s1_seq_q;
  logic [7:0]      s1_risk_q, s1_level_q;

  logic [15:0]     cnt_q [N_CH];
  logic [N_CH-1:0] fin_q;
  logic [15:0]     rej_cnt_q;

  logic            push_d, pop_d, fifo_vld;
  logic [FW-1:0]   fifo_din, fifo_dout;

  // Ready reflects reserved space (queued plus in-flight S1) so S1 never stalls.
  assign bus.in_ready = rst_n && ((32'(fifo_level) + 32'(s1_vld_q)) < 32'(DEPTH));

  always_comb begin
    accept_d = bus.in_valid && bus.in_ready;
    reject_d = (bus.in_rec.score > DATA_W'(SCORE_MAX)) || (32'(bus.in_ch) >= 32'(N_CH));
    tier_d   = tier(bus.in_rec.score, thr_hi, thr_mid, thr_lo);
  end

`ifdef XRST_HASH_CHAIN_EN
  logic [63:0] h_q, h_d, s1_hash_q;

  assign h_d = rotl5(h_q)
             ^ {32'(bus.in_rec.sla_id), 32'(bus.in_rec.timestamp)}
             ^ {32'(bus.in_rec.score), seq_q};

  always_ff @(posedge clk) begin
    if (!rst_n)                      h_q <= HASH_SEED;
    else if (accept_d && !reject_d)  h_q <= h_d;
  end

  always_ff @(posedge clk) begin
    if (accept_d) s1_hash_q <= h_d;
  end
`endif

  // Stage 0 -> S1: capture the accepted record with its classification and sequence number.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      seq_q    <= '0;
    end else begin
      s1_vld_q <= accept_d;
      if (accept_d && !reject_d) seq_q <= seq_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_d) begin
      s1_rej_q   <= reject_d;
      s1_rec_q   <= bus.in_rec;
      s1_ch_q    <= bus.in_ch;
      s1_seq_q   <= seq_q;
      s1_risk_q  <= tier_d[15:8];
      s1_level_q <= tier_d[7:0];
    end
  end

  // S1 -> FIFO: enqueue or drop, and update per-channel and reject bookkeeping.
  assign push_d = s1_vld_q && !s1_rej_q;
  assign pop_d  = fifo_vld && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      fin_q     <= '0;
      rej_cnt_q <= '0;
    end else begin
      if (s1_vld_q && s1_rej_q) rej_cnt_q <= sat_inc16(rej_cnt_q);
      for (int i = 0; i < N_CH; i++) begin
        // A clear landing with an enqueue is applied first, leaving count=1.
        if (push_d && (32'(s1_ch_q) == i)) begin
          cnt_q[i] <= sat_inc16(ch_clear[i] ? 16'd0 : cnt_q[i]);
          fin_q[i] <= 1'b1;
        end else if (ch_clear[i]) begin
          cnt_q[i] <= '0;
          fin_q[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt
    assign ch_count[g*16 +: 16] = cnt_q[g];
  end
  assign ch_final     = fin_q;
  assign reject_count = rej_cnt_q;

`ifdef XRST_HASH_CHAIN_EN
  assign fifo_din = {s1_rec_q, s1_ch_q, s1_seq_q, s1_risk_q, s1_level_q, s1_hash_q};
  assign {bus.out_rec, bus.out_ch, bus.out_seq, bus.out_risk, bus.out_level, bus.out_hash} = fifo_dout;
`else
  assign fifo_din = {s1_rec_q, s1_ch_q, s1_seq_q, s1_risk_q, s1_level_q};
  assign {bus.out_rec, bus.out_ch, bus.out_seq, bus.out_risk, bus.out_level} = fifo_dout;
  assign bus.out_hash = 64'd0;
`endif

  xrst_sync_fifo #(
    .WIDTH   (FW),
    .DEPTH   (DEPTH),
    .RST_VAL (FIFO_RST)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_d),
    .din_i   (fifo_din),
    .pop_i   (pop_d),
    .dout_o  (fifo_dout),
    .valid_o (fifo_vld),
    .level_o (fifo_level)
  );

  assign bus.out_valid = fifo_vld;

endmodule

// File: tb/tb_xrst_settlement_ledger.sv
// Scoreboard bench for xrst_settlement_ledger; hash expectations apply when XRST_HASH_CHAIN_EN is defined.
module tb_xrst_settlement_ledger;
  import xrst_settlement_pkg::*;

  localparam int N_CH      = 3;
  localparam int DEPTH     = 8;
  localparam int SCORE_MAX = 1000;
  localparam int CH_W      = 2;
  localparam int LVL_W     = $clog2(DEPTH) + 1;
  localparam logic [63:0] HASH1 = 64'h0A4A_6941_0000_0029;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]        thr_hi = 32'd950, thr_mid = 32'd900, thr_lo = 32'd800;
  logic [N_CH-1:0]    ch_clear = '0;
  logic [N_CH*16-1:0] ch_count;
  logic [N_CH-1:0]    ch_final;
  logic [15:0]        reject_count;
  logic [LVL_W-1:0]   fifo_level;

  xrst_settlement_ledger_if #(.CH_W(CH_W)) bus ();

  xrst_settlement_ledger #(.N_CH(N_CH), .DEPTH(DEPTH), .SCORE_MAX(SCORE_MAX)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .thr_hi       (thr_hi),
    .thr_mid      (thr_mid),
    .thr_lo       (thr_lo),
    .ch_clear     (ch_clear),
    .ch_count     (ch_count),
    .ch_final     (ch_final),
    .reject_count (reject_count),
    .fifo_level   (fifo_level)
  );

  typedef struct {
    rec_t            rec;
    logic [CH_W-1:0] ch;
    logic [31:0]     seq;
    logic [7:0]      risk;
    logic [7:0]      level;
    logic [63:0]     hash;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_seq = '0;
  logic [63:0] mh = HASH_SEED;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model_hash(input logic [63:0] h, input logic [31:0] sla, ts, score, seq);
    return {h[58:0], h[63:59]} ^ {sla, ts} ^ {score, seq};
  endfunction

  function automatic rec_t mk_rec(input logic [31:0] sla, ts, score);
    rec_t r;
    r = '0;
    r.sla_id    = sla;
    r.timestamp = ts;
    r.score     = score;
    r.settle_a  = sla + 32'd7;
    r.stake     = ts ^ 32'hA5A5_0000;
    r.status    = 8'hA5;
    r.proof     = {8{sla}};
    return r;
  endfunction

  task automatic expect_push(input logic [CH_W-1:0] ch, input rec_t r, input logic [7:0] risk, level);
    exp_t e;
    e.rec   = r;
    e.ch    = ch;
    e.seq   = exp_seq;
    e.risk  = risk;
    e.level = level;
`ifdef XRST_HASH_CHAIN_EN
    mh     = model_hash(mh, r.sla_id, r.timestamp, r.score, exp_seq);
    e.hash = mh;
`else
    e.hash = 64'd0;
`endif
    exp_seq = exp_seq + 32'd1;
    sb.push_back(e);
  endtask

  task automatic send(input logic [CH_W-1:0] ch, input logic [31:0] score, sla, ts,
                      input logic [7:0] risk, level, input bit rej);
    int   n;
    rec_t r;
    n = 0;
    r = mk_rec(sla, ts, score);
    bus.in_ch    = ch;
    bus.in_rec   = r;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      check("send_ready", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    if (!rej) expect_push(ch, r, risk, level);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_left", 64'(sb.size()), 64'd0);
    check("drain_level", 64'(fifo_level), 64'd0);
  endtask

  task automatic do_reset(input bit full);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    sb.delete();
    exp_seq = '0;
    mh      = HASH_SEED;
    rst_n   = 1'b1;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("post_rst_level", 64'(fifo_level), 64'd0);
    if (full) begin
      check("post_rst_out_rec_zero", 64'(bus.out_rec == '0), 64'd1);
      check("post_rst_out_ch", 64'(bus.out_ch), 64'd0);
      check("post_rst_out_seq", 64'(bus.out_seq), 64'd0);
      check("post_rst_out_risk", 64'(bus.out_risk), 64'd100);
      check("post_rst_out_level", 64'(bus.out_level), 64'd100);
      check("post_rst_out_hash", bus.out_hash, 64'd0);
      check("post_rst_ch_count", 64'(ch_count), 64'd0);
      check("post_rst_ch_final", 64'(ch_final), 64'd0);
      check("post_rst_reject_count", 64'(reject_count), 64'd0);
    end
  endtask

  // Monitor: every handshaken output word is compared against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 64'(bus.out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("mon_rec", 64'(bus.out_rec == e.rec), 64'd1);
          check("mon_ch", 64'(bus.out_ch), 64'(e.ch));
          check("mon_seq", 64'(bus.out_seq), 64'(e.seq));
          check("mon_risk", 64'(bus.out_risk), 64'(e.risk));
          check("mon_level", 64'(bus.out_level), 64'(e.level));
          check("mon_hash", bus.out_hash, e.hash);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.in_rec    = '0;
    bus.out_ready = 1'b1;
    do_reset(1'b1);

    // First record latency and classification
    send(2'd2, 32'd960, 32'd1, 32'd2, 8'd10, 8'd100, 1'b0);
    check("lat_not_yet", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat_valid", 64'(bus.out_valid), 64'd1);
    check("first_seq", 64'(bus.out_seq), 64'd0);
    check("first_risk", 64'(bus.out_risk), 64'd10);
    check("first_level", 64'(bus.out_level), 64'd100);
    check("first_ch_count2", 64'(ch_count[2*16 +: 16]), 64'd1);
    check("first_ch_final2", 64'(ch_final[2]), 64'd1);
`ifdef XRST_HASH_CHAIN_EN
    check("first_hash", bus.out_hash, HASH1);
`else
    check("first_hash", bus.out_hash, 64'd0);
`endif
    drain(20);

    // Back-to-back tiers, then threshold edges
    do_reset(1'b0);
    send(2'd0, 32'd920,  32'd11, 32'd100, 8'd30, 8'd90,  1'b0);
    send(2'd1, 32'd850,  32'd12, 32'd101, 8'd60, 8'd75,  1'b0);
    send(2'd0, 32'd100,  32'd13, 32'd102, 8'd90, 8'd50,  1'b0);
    send(2'd1, 32'd950,  32'd14, 32'd103, 8'd10, 8'd100, 1'b0);
    send(2'd2, 32'd1000, 32'd15, 32'd104, 8'd10, 8'd100, 1'b0);
    send(2'd0, 32'd800,  32'd16, 32'd105, 8'd60, 8'd75,  1'b0);
    send(2'd2, 32'd799,  32'd17, 32'd106, 8'd90, 8'd50,  1'b0);
    drain(40);

    // Misordered thresholds: first match still wins
    thr_hi = 32'd100; thr_mid = 32'd500; thr_lo = 32'd900;
    send(2'd1, 32'd600, 32'd21, 32'd200, 8'd10, 8'd100, 1'b0);
    send(2'd1, 32'd50,  32'd22, 32'd201, 8'd90, 8'd50,  1'b0);
    drain(20);
    thr_hi = 32'd950; thr_mid = 32'd900; thr_lo = 32'd800;

    // Backpressure: fill to DEPTH, then release
    do_reset(1'b0);
    bus.out_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < DEPTH + 6; k++) begin
      if (bus.in_ready) begin
        bus.in_ch    = CH_W'(k % N_CH);
        bus.in_rec   = mk_rec(32'(100 + k), 32'(k), 32'd905);
        bus.in_valid = 1'b1;
        expect_push(CH_W'(k % N_CH), mk_rec(32'(100 + k), 32'(k), 32'd905), 8'd30, 8'd90);
        acc++;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("fill_accepted", 64'(acc), 64'(DEPTH));
    check("fill_level", 64'(fifo_level), 64'(DEPTH));
    check("fill_ready_low", 64'(bus.in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("hold_valid", 64'(bus.out_valid), 64'd1);
    check("hold_seq", 64'(bus.out_seq), 64'd0);
    bus.out_ready = 1'b1;
    #1;
    check("ready_before_pop", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    check("ready_after_pop", 64'(bus.in_ready), 64'd1);
    check("level_after_pop", 64'(fifo_level), 64'(DEPTH - 1));
    drain(40);

    // Rejects: bad score, bad channel; seq and hash unaffected
    do_reset(1'b0);
    send(2'd0, 32'd1001, 32'd31, 32'd300, 8'd0, 8'd0, 1'b1);
    send(2'd3, 32'd5,    32'd32, 32'd301, 8'd0, 8'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("reject_count", 64'(reject_count), 64'd2);
    check("reject_no_valid", 64'(bus.out_valid), 64'd0);
    check("reject_level", 64'(fifo_level), 64'd0);
    check("reject_ch_count", 64'(ch_count), 64'd0);
    send(2'd2, 32'd960, 32'd1, 32'd2, 8'd10, 8'd100, 1'b0);
    drain(20);

    // Per-channel counting and clear/enqueue collision
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) send(2'd1, 32'd960, 32'(40 + k), 32'(k), 8'd10, 8'd100, 1'b0);
    send(2'd0, 32'd10, 32'd50, 32'd0, 8'd90, 8'd50, 1'b0);
    drain(30);
    check("ch1_count5", 64'(ch_count[1*16 +: 16]), 64'd5);
    check("ch0_count1", 64'(ch_count[0*16 +: 16]), 64'd1);
    send(2'd1, 32'd960, 32'd51, 32'd9, 8'd10, 8'd100, 1'b0);
    ch_clear = 3'b010;
    @(posedge clk); #1;
    ch_clear = 3'b000;
    check("clear_enq_count", 64'(ch_count[1*16 +: 16]), 64'd1);
    check("clear_enq_final", 64'(ch_final[1]), 64'd1);
    ch_clear = 3'b001;
    @(posedge clk); #1;
    ch_clear = 3'b000;
    check("clear_only_count", 64'(ch_count[0*16 +: 16]), 64'd0);
    check("clear_only_final", 64'(ch_final[0]), 64'd0);
    drain(20);

    // Sequence counter wrap
    force dut.seq_q = 32'hFFFF_FFFF;
    #1;
    release dut.seq_q;
    exp_seq = 32'hFFFF_FFFF;
    send(2'd0, 32'd960, 32'd61, 32'd600, 8'd10, 8'd100, 1'b0);
    send(2'd2, 32'd910, 32'd62, 32'd601, 8'd30, 8'd90,  1'b0);
    drain(20);

    // Mid-stream reset flushes the FIFO and restarts the hash from the seed
    bus.out_ready = 1'b0;
    send(2'd0, 32'd960, 32'd71, 32'd700, 8'd10, 8'd100, 1'b0);
    send(2'd1, 32'd860, 32'd72, 32'd701, 8'd60, 8'd75,  1'b0);
    send(2'd2, 32'd700, 32'd73, 32'd702, 8'd90, 8'd50,  1'b0);
    @(posedge clk); #1;
    check("pre_rst_level", 64'(fifo_level), 64'd3);
    do_reset(1'b0);
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;
    send(2'd2, 32'd960, 32'd1, 32'd2, 8'd10, 8'd100, 1'b0);
    @(posedge clk); #1;
    check("restart_valid", 64'(bus.out_valid), 64'd1);
    check("restart_seq", 64'(bus.out_seq), 64'd0);
`ifdef XRST_HASH_CHAIN_EN
    check("restart_hash", bus.out_hash, HASH1);
`else
    check("restart_hash", bus.out_hash, 64'd0);
`endif
    drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
